// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit computer: T-state counter, halt latch and control-word decode.
// Optional macro SEQ_EARLY_END_EN ends an instruction as soon as its next microstep would be empty.
module control_sequencer #(
    parameter int NUM_STEPS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    function automatic logic [15:0] decode(input logic [2:0] s, input logic [3:0] op,
                                           input logic c, input logic z);
        logic [15:0] w;
        w = '0;
        case (s)
            3'd0: w = CO | MI;
            3'd1: w = RO | II | CE;
            3'd2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w = IO | MI;
                    OP_LDI: w = IO | AI;
                    OP_JMP: w = IO | J;
                    OP_JC:  w = c ? (IO | J) : 16'h0000;
                    OP_JZ:  w = z ? (IO | J) : 16'h0000;
                    OP_OUT: w = AO | OI;
                    OP_HLT: w = HLT;
                    default: w = '0;
                endcase
            end
            3'd3: begin
                case (op)
                    OP_LDA:         w = RO | AI;
                    OP_ADD, OP_SUB: w = RO | BI;
                    OP_STA:         w = AO | RI;
                    default:        w = '0;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_ADD:  w = EO | AI | FI;
                    OP_SUB:  w = EO | AI | FI | SU;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        ctrl = halted ? 16'h0000 : decode(step, opcode, flag_c, flag_z);
    end

    logic early_end;
`ifdef SEQ_EARLY_END_EN
    // Conditional jumps look ahead as if taken, so an untaken jump still
    // spends its (empty) T2 and takes three steps like a taken one.
    always_comb begin
        early_end = (step != 3'd0) &&
                    (decode(step + 3'd1, opcode, 1'b1, 1'b1) == 16'h0000);
    end
`else
    always_comb begin
        early_end = 1'b0;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of step, halted and ctrl.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else if (step_en && !halted) begin
            if (ctrl[15]) begin
                halted <= 1'b1;
            end else if (step == LAST_STEP || early_end) begin
                step <= 3'd0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: stimulus drives step_en pulses and
// check() compares (step, ctrl, halted) on the following falling edge.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_en = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    control_sequencer #(.NUM_STEPS(5)) dut (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .ctrl(ctrl), .step(step), .halted(halted)
    );

    always #5 clk = ~clk;

    int   n_compared = 0;
    int   n_mismatched = 0;

    task automatic check(input string name, input logic [2:0] s,
                         input logic [15:0] c, input logic h);
        @(negedge clk);
        n_compared++;
        if (step !== s || ctrl !== c || halted !== h) begin
            n_mismatched++;
            $display("FAIL %s: got step=%0d ctrl=%h halted=%b, want step=%0d ctrl=%h halted=%b",
                     name, step, ctrl, halted, s, c, h);
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; step_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; step_en = 1'b1;
            @(posedge clk); #1; step_en = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [2:0]  lda_s [5];
        logic [15:0] lda_c [5];
        int          lda_n;

        // LDA walk-through
        do_reset();
        opcode = 4'h1;
        check("reset_t0", 3'd0, 16'h4004, 1'b0);
        if (EARLY) begin
            lda_s = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
            lda_c = '{16'h1408, 16'h4800, 16'h1200, 16'h4004, 16'h4004};
            lda_n = 4;
        end else begin
            lda_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
            lda_c = '{16'h1408, 16'h4800, 16'h1200, 16'h0000, 16'h4004};
            lda_n = 5;
        end
        for (int i = 0; i < lda_n; i++) begin
            pulse(1);
            check($sformatf("lda_pulse%0d", i + 1), lda_s[i], lda_c[i], 1'b0);
        end

        // ADD / SUB, plus opcode change at T1 is invisible
        do_reset();
        opcode = 4'h2;
        pulse(1);
        opcode = 4'hF;
        check("t1_opcode_indep", 3'd1, 16'h1408, 1'b0);
        opcode = 4'h2;
        pulse(2);
        check("add_t3", 3'd3, 16'h1020, 1'b0);
        pulse(1);
        check("add_t4", 3'd4, 16'h0281, 1'b0);
        do_reset();
        opcode = 4'h3;
        pulse(3);
        check("sub_t3", 3'd3, 16'h1020, 1'b0);
        pulse(1);
        check("sub_t4", 3'd4, 16'h02C1, 1'b0);
        pulse(1);
        check("sub_wrap", 3'd0, 16'h4004, 1'b0);

        // conditional jumps, flags re-decoded combinationally
        do_reset();
        opcode = 4'h7; flag_c = 1'b1;
        pulse(2);
        check("jc_taken", 3'd2, 16'h0802, 1'b0);
        flag_c = 1'b0;
        check("jc_untaken", 3'd2, 16'h0000, 1'b0);
        do_reset();
        opcode = 4'h8; flag_z = 1'b1;
        pulse(2);
        check("jz_taken", 3'd2, 16'h0802, 1'b0);
        flag_z = 1'b0; flag_c = 1'b1;
        check("jz_untaken", 3'd2, 16'h0000, 1'b0);
        flag_c = 1'b0;

        // other T2 words
        do_reset(); opcode = 4'hE; pulse(2);
        check("out_t2", 3'd2, 16'h0110, 1'b0);
        do_reset(); opcode = 4'h5; pulse(2);
        check("ldi_t2", 3'd2, 16'h0A00, 1'b0);
        do_reset(); opcode = 4'h6; pulse(2);
        check("jmp_t2", 3'd2, 16'h0802, 1'b0);
        do_reset(); opcode = 4'h4; pulse(3);
        check("sta_t3", 3'd3, 16'h2100, 1'b0);
        do_reset(); opcode = 4'hD; pulse(2);
        check("undef_op_t2", EARLY ? 3'd0 : 3'd2, EARLY ? 16'h4004 : 16'h0000, 1'b0);

        // halt
        do_reset(); opcode = 4'hF; pulse(2);
        check("hlt_t2", 3'd2, 16'h8000, 1'b0);
        pulse(1);
        check("hlt_latched", 3'd2, 16'h0000, 1'b1);
        pulse(10);
        check("hlt_frozen", 3'd2, 16'h0000, 1'b1);
        do_reset();
        check("hlt_reset", 3'd0, 16'h4004, 1'b0);

        // reset wins over step_en; hold with step_en low
        opcode = 4'h2;
        pulse(3);
        check("pre_reset_t3", 3'd3, 16'h1020, 1'b0);
        @(posedge clk); #1; rst_n = 1'b0; step_en = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1; step_en = 1'b0;
        check("reset_over_en", 3'd0, 16'h4004, 1'b0);
        pulse(2);
        repeat (20) @(posedge clk);
        #1;
        check("hold_20", 3'd2, 16'h4800, 1'b0);

        // step_en held high advances every cycle
        do_reset(); opcode = 4'h2;
        @(posedge clk); #1; step_en = 1'b1;
        repeat (3) @(posedge clk);
        #1; step_en = 1'b0;
        check("continuous_en", 3'd3, 16'h1020, 1'b0);

        // NOP sequence length
        do_reset(); opcode = 4'h0;
        pulse(1);
        check("nop_t1", 3'd1, 16'h1408, 1'b0);
        pulse(1);
        check("nop_t2", EARLY ? 3'd0 : 3'd2, EARLY ? 16'h4004 : 16'h0000, 1'b0);
        if (!EARLY) begin
            pulse(3);
            check("nop_wrap", 3'd0, 16'h4004, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
